// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Used by the unified memory port arbiter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FETCH
  } arb_state_t;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;
  localparam int MEM_MAX_WAIT = 15;

endpackage

// File: rtl/mem_wait_timer.sv
// 8-bit wait counter for outstanding memory requests.
// expired_o flags the last permitted cycle without an ack.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired_o = en_i & (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and MEM stages.
// Data access goes first, then fetch; stall until both finish.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MEM_MAX_WAIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ARB_ERR_DATA);

  arb_state_t state;
  logic dm_done;
  logic if_done;
  logic dm_need;
  logic if_need;
  logic busy;
  logic timeout;
  logic finish;

  assign dm_need = (dm_read_i | dm_write_i) & ~dm_done;
  assign if_need = if_req_i & ~if_done;
  assign stall_o = dm_need | if_need;
  assign busy    = (state != IDLE);
  assign finish  = busy & (mem_ack_i | timeout);

  // Cleared while idle and on completion so each state entry starts at 0.
  mem_wait_timer #(
    .LIMIT(MAX_WAIT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (~busy | finish),
    .en_i     (busy & ~mem_ack_i),
    .expired_o(timeout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      dm_done    <= 1'b0;
      if_done    <= 1'b0;
      if_rdata_o <= '0;
      dm_rdata_o <= '0;
      err_o      <= 1'b0;
    end else begin
      if (!stall_o) begin
        dm_done <= 1'b0;
        if_done <= 1'b0;
      end
      if (timeout) begin
        err_o <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (mem_ack_i) begin
            err_o <= 1'b1;
          end
          if (dm_need) begin
            state <= DATA;
          end else if (if_need) begin
            state <= FETCH;
          end
        end
        DATA: begin
          if (dm_read_i & dm_write_i) begin
            err_o <= 1'b1;
          end
          if (finish) begin
            if (timeout) begin
              dm_rdata_o <= ERR_WORD;
            end else if (!dm_write_i) begin
              dm_rdata_o <= mem_rdata_i;
            end
            dm_done <= 1'b1;
            state   <= if_need ? FETCH : IDLE;
          end
        end
        FETCH: begin
          if (finish) begin
            if_rdata_o <= timeout ? ERR_WORD : mem_rdata_i;
            if_done    <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port fields decode from state; sources are frozen by the stall.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state)
      DATA: begin
        mem_req_o   = 1'b1;
        mem_we_o    = dm_write_i;
        mem_addr_o  = dm_addr_i;
        mem_wdata_o = dm_wdata_i;
      end
      FETCH: begin
        mem_req_o  = 1'b1;
        mem_addr_o = if_addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Memory requests are checked against a scoreboard queue.
module tb_mem_port_arbiter;

  localparam int MAXW = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        dm_read_i;
  logic        dm_write_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          wait_cyc;
    logic [31:0] rdata;
  } req_t;

  req_t sbq[$];
  int checks = 0;
  int failures = 0;
  int we_n;
  bit seen;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .dm_read_i  (dm_read_i),
    .dm_write_i (dm_write_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_rdata_o (dm_rdata_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i),
    .err_o      (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input int wc,
                          input logic [31:0] rd);
    req_t r;
    r.addr = a;
    r.we = w;
    r.wdata = wd;
    r.wait_cyc = wc;
    r.rdata = rd;
    sbq.push_back(r);
  endtask

  task automatic clear_inputs();
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    dm_read_i  = 1'b0;
    dm_write_i = 1'b0;
    dm_addr_i  = '0;
    dm_wdata_i = '0;
    mem_ack_i  = 1'b0;
    mem_rdata_i = '0;
  endtask

  // One pipeline step: respond to requests, count stall cycles.
  task automatic run_step(input string tag, input logic [31:0] exp_if,
                          input logic [31:0] exp_dm, input int exp_stall,
                          output int wes);
    req_t cur;
    int stall_n = 0;
    int age = 0;
    int cur_len = 0;
    bit active = 0;
    bit done = 0;
    wes = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (!stall_o) begin
        done = 1;
        break;
      end
      stall_n++;
      if (mem_req_o) begin
        if (mem_we_o) wes++;
        if (!active) begin
          if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd1);
          end else begin
            cur = sbq.pop_front();
            chk({tag, "_addr"}, mem_addr_o, cur.addr);
            chk({tag, "_we"}, 32'(mem_we_o), 32'(cur.we));
            if (cur.we) chk({tag, "_wdata"}, mem_wdata_o, cur.wdata);
            active = 1;
            age = 0;
            cur_len = (cur.wait_cyc >= MAXW) ? MAXW : cur.wait_cyc + 1;
          end
        end
        if (active) begin
          if (age == cur.wait_cyc && cur.wait_cyc < MAXW) begin
            mem_ack_i = 1'b1;
            mem_rdata_i = cur.rdata;
          end
          age++;
          if (age == cur_len) active = 0;
        end
      end
    end
    chk({tag, "_finished"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    chk({tag, "_if_rdata"}, if_rdata_o, exp_if);
    chk({tag, "_dm_rdata"}, dm_rdata_o, exp_dm);
    chk({tag, "_sb_left"}, 32'(sbq.size()), 32'd0);
    @(posedge clk_i);
    #1;
    clear_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_dm_rdata", dm_rdata_o, 32'd0);
    chk("rst_stall_idle", 32'(stall_o), 32'd0);
    if_req_i = 1'b1;
    #1;
    chk("rst_stall_pend", 32'(stall_o), 32'd1);
    rst_i = 1'b0;

    push_req(32'h0, 1'b0, 32'h0, 0, 32'h2002000A);
    run_step("fetch0", 32'h2002000A, 32'h0, 2, we_n);

    dm_read_i = 1'b1;
    dm_addr_i = 32'h40;
    if_req_i  = 1'b1;
    if_addr_i = 32'h8;
    push_req(32'h40, 1'b0, 32'h0, 2, 32'h11);
    push_req(32'h8, 1'b0, 32'h0, 2, 32'h22);
    run_step("ld_fetch", 32'h22, 32'h11, 7, we_n);
    chk("ld_fetch_we_cycles", 32'(we_n), 32'd0);

    dm_write_i = 1'b1;
    dm_addr_i  = 32'h10;
    dm_wdata_i = 32'hCAFE;
    push_req(32'h10, 1'b1, 32'hCAFE, 0, 32'hBAD0BAD0);
    run_step("store", 32'h22, 32'h11, 2, we_n);
    chk("store_we_cycles", 32'(we_n), 32'd1);
    chk("store_err", 32'(err_o), 32'd0);

    dm_read_i = 1'b1;
    dm_addr_i = 32'h44;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        seen = 1;
        break;
      end
    end
    chk("mid_req_seen", 32'(seen), 32'd1);
    chk("mid_req_addr", mem_addr_o, 32'h44);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_req_drop", 32'(mem_req_o), 32'd0);
    chk("mid_rst_dm_rdata", dm_rdata_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    push_req(32'h44, 1'b0, 32'h0, 0, 32'h77);
    run_step("reissue", 32'h0, 32'h77, 2, we_n);

    if_req_i  = 1'b1;
    if_addr_i = 32'h20;
    push_req(32'h20, 1'b0, 32'h0, 255, 32'h0);
    run_step("timeout", 32'hDEADBEEF, 32'h77, 16, we_n);
    chk("timeout_err", 32'(err_o), 32'd1);

    if_req_i  = 1'b1;
    if_addr_i = 32'h24;
    push_req(32'h24, 1'b0, 32'h0, 1, 32'h1234);
    run_step("after_to", 32'h1234, 32'h77, 3, we_n);
    chk("err_sticky", 32'(err_o), 32'd1);

    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("err_cleared", 32'(err_o), 32'd0);
    dm_read_i  = 1'b1;
    dm_write_i = 1'b1;
    dm_addr_i  = 32'h30;
    dm_wdata_i = 32'h55;
    push_req(32'h30, 1'b1, 32'h55, 0, 32'h999);
    run_step("rw_both", 32'h0, 32'h0, 2, we_n);
    chk("rw_both_we_cycles", 32'(we_n), 32'd1);
    chk("rw_both_err", 32'(err_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
